exe_stage: RTL and testbench

//  Execute stage of the 5-stage LoongArch pipeline; sits between the decode stage and the memory stage.
//  - Latches the decode-to-execute bus and runs the ALU.
//  - Issues data-SRAM requests for ld.w/st.w.
//  - Forwards {res_from_mem, rf_we, rf_waddr, result} back to decode for bypass and load-use stalls.
//  - Passes the result to the memory stage through a valid/allowin handshake.

---
 rtl/exe_stage_pkg.sv | 57 +++++
 rtl/exe_stage_if.sv | 22 ++
 rtl/exe_stage_alu.sv | 30 +++
 rtl/exe_stage.sv | 102 ++++++++++
 tb/tb_exe_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, bus field offsets, ALU op indices.
package cpu_pipe_pkg;

    localparam int DS_TO_ES_BUS_W  = 148;
    localparam int ES_TO_MS_BUS_W  = 71;
    localparam int ES_RF_COLLECT_W = 39;

    // ds_to_es_bus = {alu_op, res_from_mem, src1, src2, mem_we, rf_we, rf_waddr, rkd_value, pc}
    localparam int DS_PC_LSB       = 0;
    localparam int DS_PC_MSB       = 31;
    localparam int DS_RKD_LSB      = 32;
    localparam int DS_RKD_MSB      = 63;
    localparam int DS_WADDR_LSB    = 64;
    localparam int DS_WADDR_MSB    = 68;
    localparam int DS_RF_WE        = 69;
    localparam int DS_MEM_WE       = 70;
    localparam int DS_SRC2_LSB     = 71;
    localparam int DS_SRC2_MSB     = 102;
    localparam int DS_SRC1_LSB     = 103;
    localparam int DS_SRC1_MSB     = 134;
    localparam int DS_RES_FROM_MEM = 135;
    localparam int DS_ALU_OP_LSB   = 136;
    localparam int DS_ALU_OP_MSB   = 147;

    // es_to_ms_bus = {res_from_mem, rf_we, rf_waddr, alu_result, pc}
    localparam int MS_PC_LSB       = 0;
    localparam int MS_PC_MSB       = 31;
    localparam int MS_RESULT_LSB   = 32;
    localparam int MS_RESULT_MSB   = 63;
    localparam int MS_WADDR_LSB    = 64;
    localparam int MS_WADDR_MSB    = 68;
    localparam int MS_RF_WE        = 69;
    localparam int MS_RES_FROM_MEM = 70;

    // es_rf_collect = {res_from_mem, rf_we, rf_waddr, alu_result}
    localparam int RC_RESULT_LSB   = 0;
    localparam int RC_RESULT_MSB   = 31;
    localparam int RC_WADDR_LSB    = 32;
    localparam int RC_WADDR_MSB    = 36;
    localparam int RC_RF_WE        = 37;
    localparam int RC_RES_FROM_MEM = 38;

    localparam int ALU_OP_W = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

endpackage

// File: rtl/exe_stage_if.sv
// Pipeline handshake between decode, execute and memory stages; slave = execute-stage view.
interface exe_stage_if;
    import cpu_pipe_pkg::*;

    logic                      ds_to_es_valid;
    logic                      es_allowin;
    logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus;
    logic                      ms_allowin;
    logic                      es_to_ms_valid;
    logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus;

    modport slave (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
        output es_allowin, es_to_ms_valid, es_to_ms_bus
    );

    modport master (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus
    );

endinterface

// File: rtl/exe_stage_alu.sv
// Combinational one-hot ALU; an all-zero op vector yields zero.
module alu
    import cpu_pipe_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         src1,
    input  logic [31:0]         src2,
    output logic [31:0]         result
);

    logic [4:0] shamt;
    assign shamt = src2[4:0];

    always_comb begin
        result = '0;
        if (alu_op[ALU_ADD])  result = result | (src1 + src2);
        if (alu_op[ALU_SUB])  result = result | (src1 - src2);
        if (alu_op[ALU_SLT])  result = result | {31'b0, $signed(src1) < $signed(src2)};
        if (alu_op[ALU_SLTU]) result = result | {31'b0, src1 < src2};
        if (alu_op[ALU_AND])  result = result | (src1 & src2);
        if (alu_op[ALU_NOR])  result = result | ~(src1 | src2);
        if (alu_op[ALU_OR])   result = result | (src1 | src2);
        if (alu_op[ALU_XOR])  result = result | (src1 ^ src2);
        if (alu_op[ALU_SLL])  result = result | (src1 << shamt);
        if (alu_op[ALU_SRL])  result = result | (src1 >> shamt);
        if (alu_op[ALU_SRA])  result = result | 32'($signed(src1) >>> shamt);
        if (alu_op[ALU_LUI])  result = result | src2;
    end

endmodule

// File: rtl/exe_stage.sv
// LoongArch execute stage: latches decode bus, runs the ALU, issues data-SRAM requests.
// Optional macro ES_PERF_CNT_EN adds es_inst_cnt / es_stall_cnt counter ports.
module exe_stage
    import cpu_pipe_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    exe_stage_if.slave                 pipe,
    output logic [ES_RF_COLLECT_W-1:0] es_rf_collect,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
`ifdef ES_PERF_CNT_EN
    ,
    output logic [31:0]                es_inst_cnt,
    output logic [31:0]                es_stall_cnt
`endif
);

    logic                      es_valid;
    logic                      es_ready_go;
    logic                      handoff;
    logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus_r;

    logic [ALU_OP_W-1:0] alu_op;
    logic                res_from_mem;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic                mem_we;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rkd_value;
    logic [31:0]         pc;
    logic [31:0]         alu_result;

    assign es_ready_go         = 1'b1;
    assign pipe.es_allowin     = ~es_valid | (es_ready_go & pipe.ms_allowin);
    assign pipe.es_to_ms_valid = es_valid & es_ready_go;
    assign handoff             = pipe.es_to_ms_valid & pipe.ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (pipe.es_allowin) begin
            es_valid <= pipe.ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_to_es_bus_r <= '0;
        end else if (pipe.ds_to_es_valid && pipe.es_allowin) begin
            ds_to_es_bus_r <= pipe.ds_to_es_bus;
        end
    end

    assign alu_op       = ds_to_es_bus_r[DS_ALU_OP_MSB:DS_ALU_OP_LSB];
    assign res_from_mem = ds_to_es_bus_r[DS_RES_FROM_MEM];
    assign src1         = ds_to_es_bus_r[DS_SRC1_MSB:DS_SRC1_LSB];
    assign src2         = ds_to_es_bus_r[DS_SRC2_MSB:DS_SRC2_LSB];
    assign mem_we       = ds_to_es_bus_r[DS_MEM_WE];
    assign rf_we        = ds_to_es_bus_r[DS_RF_WE];
    assign rf_waddr     = ds_to_es_bus_r[DS_WADDR_MSB:DS_WADDR_LSB];
    assign rkd_value    = ds_to_es_bus_r[DS_RKD_MSB:DS_RKD_LSB];
    assign pc           = ds_to_es_bus_r[DS_PC_MSB:DS_PC_LSB];

    alu u_alu (
        .alu_op (alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    assign pipe.es_to_ms_bus = {res_from_mem, rf_we, rf_waddr, alu_result, pc};

    // Gate with reset so an in-flight store never writes during the reset cycle.
    assign data_sram_en    = handoff & (res_from_mem | mem_we) & ~reset;
    assign data_sram_we    = {4{mem_we & handoff & ~reset}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    // Bubbles must never match in decode's bypass/load-use comparison.
    assign es_rf_collect = {res_from_mem & es_valid, rf_we & es_valid, rf_waddr, alu_result};

`ifdef ES_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            es_inst_cnt  <= '0;
            es_stall_cnt <= '0;
        end else begin
            if (handoff) begin
                es_inst_cnt <= es_inst_cnt + 32'd1;
            end
            if (es_valid && !pipe.ms_allowin) begin
                es_stall_cnt <= es_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected handoffs, a negedge monitor pops and compares.
module tb_exe_stage;
    import cpu_pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic [38:0] es_rf_collect;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
`ifdef ES_PERF_CNT_EN
    logic [31:0] es_inst_cnt;
    logic [31:0] es_stall_cnt;
`endif

    exe_stage_if pipe ();

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pipe            (pipe),
        .es_rf_collect   (es_rf_collect),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
`ifdef ES_PERF_CNT_EN
        ,
        .es_inst_cnt     (es_inst_cnt),
        .es_stall_cnt    (es_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [70:0] bus;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } alu_vec_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned we_cycles = 0;
    int          cyc = 0;
    int          hand_cyc[bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [11:0] oh(input int idx);
        logic [11:0] v;
        v = '0;
        if (idx >= 0 && idx < 12) v[idx] = 1'b1;
        return v;
    endfunction

    // Monitor: compares every handoff against the scoreboard; no SRAM access otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("rst_sram_en", 71'(data_sram_en), 71'(0));
                check("rst_sram_we", 71'(data_sram_we), 71'(0));
            end else if (pipe.es_to_ms_valid && pipe.ms_allowin) begin
                if (data_sram_we != 4'h0) we_cycles++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_handoff: got bus %h expected none", pipe.es_to_ms_bus);
                end else begin
                    e = sb.pop_front();
                    check("ms_bus", pipe.es_to_ms_bus, e.bus);
                    check("sram_en", 71'(data_sram_en), 71'(e.en));
                    check("sram_we", 71'(data_sram_we), 71'(e.we));
                    if (e.en) check("sram_addr", 71'(data_sram_addr), 71'(e.addr));
                    if (e.we != 4'h0) check("sram_wdata", 71'(data_sram_wdata), 71'(e.wdata));
                    hand_cyc[e.bus[31:0]] = cyc;
                end
            end else begin
                check("idle_sram_en", 71'(data_sram_en), 71'(0));
                check("idle_sram_we", 71'(data_sram_we), 71'(0));
            end
        end
    end

    task automatic issue(input logic [11:0] op, input logic rm, input logic [31:0] s1, input logic [31:0] s2,
                         input logic mw, input logic rw, input logic [4:0] wa, input logic [31:0] rkd,
                         input logic [31:0] pc, input logic [31:0] exp_res);
        exp_t e;
        bit   acc;
        acc     = 1'b0;
        e.bus   = {rm, rw, wa, exp_res, pc};
        e.en    = rm | mw;
        e.we    = {4{mw}};
        e.addr  = exp_res;
        e.wdata = rkd;
        sb.push_back(e);
        pipe.ds_to_es_valid = 1'b1;
        pipe.ds_to_es_bus   = {op, rm, s1, s2, mw, rw, wa, rkd, pc};
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = pipe.es_allowin;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got es_allowin 0 expected 1 (pc %h)", pc);
        end
        pipe.ds_to_es_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !pipe.es_to_ms_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_left", 71'(sb.size()), 71'(0));
    endtask

    alu_vec_t vecs[13] = '{
        '{ALU_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001},
        '{ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE},
        '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
        '{ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F},
        '{ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678},
        '{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F},
        '{ALU_SLL,  32'h00000001, 32'h00000024, 32'h00000010},
        '{ALU_SRL,  32'h80000000, 32'h00000024, 32'h08000000},
        '{ALU_SRA,  32'h80000000, 32'h00000024, 32'hF8000000},
        '{ALU_LUI,  32'h00000123, 32'hABCDE000, 32'hABCDE000},
        '{12,       32'h00000005, 32'h00000007, 32'h00000000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        pipe.ms_allowin     = 1'b1;
        pipe.ds_to_es_valid = 1'b0;
        pipe.ds_to_es_bus   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_ms_valid", 71'(pipe.es_to_ms_valid), 71'(0));
        check("reset_allowin", 71'(pipe.es_allowin), 71'(1));
        check("reset_ms_bus", pipe.es_to_ms_bus, 71'(0));
        check("reset_collect", 71'(es_rf_collect), 71'(0));
        @(posedge clk);
        #1;

        // add.w 5 + 7
        issue(oh(ALU_ADD), 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 5'd3, 32'd0, 32'h1C000000, 32'd12);
        @(negedge clk);
        check("add_valid", 71'(pipe.es_to_ms_valid), 71'(1));
        check("add_collect", 71'(es_rf_collect), 71'({1'b0, 1'b1, 5'd3, 32'd12}));
        drain();

        // st.w
        issue(oh(ALU_ADD), 1'b0, 32'h1000, 32'd8, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h1C000004, 32'h1008);
        drain();

        // ld.w held by memory stage for 3 cycles
        pipe.ms_allowin = 1'b0;
        issue(oh(ALU_ADD), 1'b1, 32'h2000, 32'd4, 1'b0, 1'b1, 5'd7, 32'd0, 32'h1C000008, 32'h2004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_stall_en", 71'(data_sram_en), 71'(0));
            check("ld_stall_rfm", 71'(es_rf_collect[38]), 71'(1));
            check("ld_stall_allowin", 71'(pipe.es_allowin), 71'(0));
            check("ld_stall_valid", 71'(pipe.es_to_ms_valid), 71'(1));
            @(posedge clk);
            #1;
        end
        pipe.ms_allowin = 1'b1;
        drain();

        // back-to-back ALU sweep
        foreach (vecs[i]) begin
            issue(oh(vecs[i].idx), 1'b0, vecs[i].a, vecs[i].b, 1'b0, 1'b1, 5'(i + 1), 32'd0,
                  32'h100 + 32'(i) * 32'd4, vecs[i].r);
        end
        drain();
        check("b2b_gap_1", 71'(hand_cyc[32'h104] - hand_cyc[32'h100]), 71'(1));
        check("b2b_gap_2", 71'(hand_cyc[32'h108] - hand_cyc[32'h104]), 71'(1));
        @(posedge clk);
        #1;

        // reset while a load is in flight
        pipe.ms_allowin = 1'b0;
        issue(oh(ALU_ADD), 1'b1, 32'h3000, 32'd0, 1'b0, 1'b1, 5'd9, 32'd0, 32'h300, 32'h3000);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        pipe.ms_allowin = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_ms_valid", 71'(pipe.es_to_ms_valid), 71'(0));
        check("mrst_sram_en", 71'(data_sram_en), 71'(0));
        check("mrst_flags", 71'(es_rf_collect[38:37]), 71'(0));
        @(posedge clk);
        #1;

`ifdef ES_PERF_CNT_EN
        pipe.ms_allowin = 1'b0;
        issue(oh(ALU_ADD), 1'b0, 32'd1, 32'd1, 1'b0, 1'b1, 5'd1, 32'd0, 32'h400, 32'd2);
        repeat (4) @(posedge clk);
        #1 pipe.ms_allowin = 1'b1;
        for (int i = 1; i < 10; i++) begin
            issue(oh(ALU_ADD), 1'b0, 32'(i), 32'd1, 1'b0, 1'b1, 5'd1, 32'd0, 32'h400 + 32'(i) * 32'd4, 32'(i + 1));
        end
        drain();
        check("perf_inst_cnt", 71'(es_inst_cnt), 71'(10));
        check("perf_stall_cnt", 71'(es_stall_cnt), 71'(4));
`endif

        check("store_we_cycles", 71'(we_cycles), 71'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
